fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly downstream of the PC control unit. It owns the PC register, applies the unit's pcsel, branch/jump targets and pcp4_hold to form the next PC, and runs a single-outstanding request/response handshake to instruction memory. It drives the IF/ID pipeline register, squashing the captured instruction when if_id_stall is set. if_advance is the global "pipeline steps" strobe for the downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width (only 32 supported)

Ports:
clk  in  1  clock, all flops on rising edge
rst  in  1  reset, asynchronous, active-high
pcsel  in  2  next-PC select from PC control: 0 pc+4, 1 branch target, 2 jump target, 3 pcp4_hold
br_target  in  32  branch target address
jmp_target  in  32  jump target address
pcp4_hold  in  32  saved fall-through address (not-taken recovery)
if_id_stall  in  1  1 = instruction captured on this advance is squashed
hazard_hold  in  1  freeze PC and IF/ID (load-use interlock)
pcp4  out  32  PC+4 of current PC register, combinational, to PC control
imem_req  out  1  fetch request strobe
imem_addr  out  32  fetch address (= PC)
imem_rdata  in  32  fetched instruction
imem_valid  in  1  response strobe, earliest 1 cycle after imem_req
if_advance  out  1  combinational: IF/ID updates on this edge
if_id_instr  out  32  IF/ID instruction
if_id_pcp4  out  32  IF/ID PC+4
if_id_valid  out  1  IF/ID entry holds a live instruction

Behaviour:
- Reset (async, immediate): pc=RESET_PC; state=ISSUE; buf_valid=0; if_id_instr=0 (NOP); if_id_pcp4=0; if_id_valid=0. imem_req=0 while rst is high.
- FSM states: ISSUE, WAIT, HELD.
  - ISSUE: imem_req=1, imem_addr=pc. Next state is WAIT. imem_valid in ISSUE is ignored.
  - WAIT: imem_req=0. If imem_valid and !hazard_hold, advance and go to ISSUE. If imem_valid and hazard_hold, buf<=imem_rdata, buf_valid=1, go to HELD. Otherwise stay in WAIT.
  - HELD: imem_req=0. Stay until hazard_hold=0, then advance from buf, clear buf_valid, go to ISSUE.
- if_advance = !hazard_hold && ((state==WAIT && imem_valid) || state==HELD).
- On an advance edge:
  - pc <= next_pc(pcsel).
  - if_id_instr <= imem_rdata, or buf when in HELD.
  - if_id_pcp4 <= pc+4.
  - if_id_valid <= !if_id_stall.
- pcsel, targets, pcp4_hold and if_id_stall are sampled only on advance edges. They are don't-care otherwise.
- IF/ID and PC are unchanged on every non-advance edge, including while hazard_hold=1.
- Throughput: at most one instruction per 2 cycles, with 1-cycle memory latency.
- Arithmetic: pc+4 is 32-bit modulo, so 0xFFFFFFFC+4 = 0x00000000. No alignment check; the low 2 bits pass through.
- Simultaneous events:
  - hazard_hold and imem_valid together: buffer, no advance.
  - if_id_stall with hazard_hold: no effect (no advance).
  - pcsel=3 takes pcp4_hold verbatim.
- Reset mid-WAIT or mid-HELD: any outstanding response is abandoned. The first cycle after release is ISSUE, and a late imem_valid arriving then is ignored.

Decomposition:
- Shared package (cpu_pkg): pcsel encodings PCSEL_PCP4=0, PCSEL_BR=1, PCSEL_JMP=2, PCSEL_HOLD=3; fetch state encoding; NOP constant 32'h0. The PC control unit uses the same pcsel constants.
- One sub-module: next_pc_mux, a combinational 4:1 selection of pc+4, br_target, jmp_target and pcp4_hold.

Test Plan:
- RESET_PC=0x400, 1-cycle memory, pcsel=0, no stall: imem_addr sequence 0x400, 0x404, 0x408 on successive ISSUE cycles; if_id_pcp4 = 0x404, 0x408; if_id_valid=1.
- Advance with pcsel=1, br_target=0x1000, if_id_stall=1: next imem_addr=0x1000; captured entry has if_id_valid=0; the following fetch is valid.
- Advance with pcsel=3, pcp4_hold=0x40C, then pcsel=2, jmp_target=0x2000: addresses 0x40C then 0x2000.
- hazard_hold=1 when imem_valid arrives with rdata=0xDEADBEEF: state HELD, no imem_req, IF/ID unchanged for 3 cycles. Drop hold: if_id_instr=0xDEADBEEF, then next ISSUE.
- pc=0xFFFFFFFC, pcsel=0: pcp4=0x0, next imem_addr=0x0.
- rst pulsed during WAIT, with imem_valid arriving in the first cycle after release: outputs reset immediately; the response is ignored; imem_addr=RESET_PC on the ISSUE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg: shared pcsel encodings, fetch FSM states, NOP constant.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] PCSEL_PCP4 = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_JMP  = 2'd2;
  localparam logic [1:0] PCSEL_HOLD = 2'd3;

  typedef enum logic [1:0] {
    FS_ISSUE = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HELD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_next_pc_mux.sv
// +----------------------------------------------------------------------+
// | next_pc_mux: 4:1 next-PC selection driven by pcsel.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module next_pc_mux
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      pcsel,
  input  logic [XLEN-1:0] pcp4,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  input  logic [XLEN-1:0] pcp4_hold,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pcp4;
    case (pcsel)
      PCSEL_PCP4: next_pc = pcp4;
      PCSEL_BR:   next_pc = br_target;
      PCSEL_JMP:  next_pc = jmp_target;
      PCSEL_HOLD: next_pc = pcp4_hold;
      default:    next_pc = pcp4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------+
// | fetch_stage: PC register, single-outstanding imem fetch, IF/ID reg.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pcsel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  input  logic [XLEN-1:0] pcp4_hold,
  input  logic            if_id_stall,
  input  logic            hazard_hold,
  output logic [XLEN-1:0] pcp4,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic            if_advance,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pcp4,
  output logic            if_id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pcp4_q, if_id_pcp4_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] next_pc;

  next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
    .pcsel      (pcsel),
    .pcp4       (pcp4),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .pcp4_hold  (pcp4_hold),
    .next_pc    (next_pc)
  );

  assign pcp4        = pc_q + XLEN'(4);
  assign imem_addr   = pc_q;
  // Reset already forces ISSUE, so gate the strobe while rst is held.
  assign imem_req    = (state_q == FS_ISSUE) && !rst;
  assign if_advance  = !hazard_hold &&
                       (((state_q == FS_WAIT) && imem_valid) || (state_q == FS_HELD));
  assign if_id_instr = if_id_instr_q;
  assign if_id_pcp4  = if_id_pcp4_q;
  assign if_id_valid = if_id_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    buf_valid_d   = buf_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pcp4_d  = if_id_pcp4_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      FS_ISSUE: state_d = FS_WAIT;
      FS_WAIT: begin
        if (imem_valid) begin
          if (hazard_hold) begin
            buf_d       = imem_rdata;
            buf_valid_d = 1'b1;
            state_d     = FS_HELD;
          end else begin
            state_d = FS_ISSUE;
          end
        end
      end
      FS_HELD: begin
        if (!hazard_hold) begin
          buf_valid_d = 1'b0;
          state_d     = FS_ISSUE;
        end
      end
      default: state_d = FS_ISSUE;
    endcase

    if (if_advance) begin
      pc_d          = next_pc;
      if_id_instr_d = ((state_q == FS_HELD) && buf_valid_q) ? buf_q : imem_rdata;
      if_id_pcp4_d  = pcp4;
      if_id_valid_d = !if_id_stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FS_ISSUE;
      pc_q          <= RESET_PC;
      buf_q         <= NOP_INSTR;
      buf_valid_q   <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pcp4_q  <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pcp4_q  <= if_id_pcp4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +----------------------------------------------------------------------+
// | tb_fetch_stage: table-driven fetch vectors plus hold/reset sequences.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsel;
  logic [31:0] br_target, jmp_target, pcp4_hold;
  logic        if_id_stall, hazard_hold;
  logic [31:0] pcp4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        if_advance;
  logic [31:0] if_id_instr, if_id_pcp4;
  logic        if_id_valid;

  fetch_stage #(.RESET_PC(32'h0000_0400), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcsel       (pcsel),
    .br_target   (br_target),
    .jmp_target  (jmp_target),
    .pcp4_hold   (pcp4_hold),
    .if_id_stall (if_id_stall),
    .hazard_hold (hazard_hold),
    .pcp4        (pcp4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .if_advance  (if_advance),
    .if_id_instr (if_id_instr),
    .if_id_pcp4  (if_id_pcp4),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pcsel;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] hold;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
  } ifid_t;

  vec_t  vecs[9];
  ifid_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic scramble_dont_cares();
    pcsel       = 2'($urandom);
    br_target   = $urandom;
    jmp_target  = $urandom;
    pcp4_hold   = $urandom;
    if_id_stall = 1'($urandom);
  endtask

  task automatic sb_compare();
    ifid_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("if_id_instr", if_id_instr, e.instr);
      check("if_id_pcp4", if_id_pcp4, e.pcp4);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_req !== 1'b1) check("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  // One full fetch: ISSUE cycle, then a 1-cycle response in WAIT that advances.
  task automatic fetch(input vec_t v);
    wait_req();
    check("imem_addr", imem_addr, v.exp_addr);
    check("pcp4", pcp4, v.exp_addr + 32'd4);
    @(posedge clk); #1;
    check("req_in_wait", {31'b0, imem_req}, 32'd0);
    imem_valid  = 1'b1;
    imem_rdata  = v.rdata;
    pcsel       = v.pcsel;
    br_target   = v.br;
    jmp_target  = v.jmp;
    pcp4_hold   = v.hold;
    if_id_stall = v.stall;
    #1;
    check("if_advance", {31'b0, if_advance}, 32'd1);
    sb.push_back('{v.rdata, v.exp_addr + 32'd4, !v.stall});
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    scramble_dont_cares();
    sb_compare();
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'h0,         32'h0,    32'h0,     1'b0, 32'h1111_1111, 32'h0000_0400};
    vecs[1] = '{2'd0, 32'h0,         32'h0,    32'h0,     1'b0, 32'h2222_2222, 32'h0000_0404};
    vecs[2] = '{2'd1, 32'h1000,      32'h0,    32'h0,     1'b1, 32'h3333_3333, 32'h0000_0408};
    vecs[3] = '{2'd0, 32'h0,         32'h0,    32'h0,     1'b0, 32'h4444_4444, 32'h0000_1000};
    vecs[4] = '{2'd3, 32'h0,         32'h0,    32'h40C,   1'b0, 32'h5555_5555, 32'h0000_1004};
    vecs[5] = '{2'd2, 32'h0,         32'h2000, 32'h0,     1'b0, 32'h6666_6666, 32'h0000_040C};
    vecs[6] = '{2'd1, 32'hFFFF_FFFC, 32'h0,    32'h0,     1'b0, 32'h7777_7777, 32'h0000_2000};
    vecs[7] = '{2'd0, 32'h0,         32'h0,    32'h0,     1'b0, 32'h8888_8888, 32'hFFFF_FFFC};
    vecs[8] = '{2'd0, 32'h0,         32'h0,    32'h0,     1'b0, 32'h9999_9999, 32'h0000_0000};

    rst = 1'b1;
    hazard_hold = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    scramble_dont_cares();
    #12;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0400);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pcp4", if_id_pcp4, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 9; i++) fetch(vecs[i]);

    // Response arrives together with hazard_hold: buffered, no advance.
    wait_req();
    check("hz_addr", imem_addr, 32'h0000_0004);
    @(posedge clk); #1;
    imem_valid  = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    hazard_hold = 1'b1;
    #1;
    check("hz_no_adv", {31'b0, if_advance}, 32'd0);
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      check("held_req", {31'b0, imem_req}, 32'd0);
      check("held_adv", {31'b0, if_advance}, 32'd0);
      check("held_instr", if_id_instr, 32'h9999_9999);
      check("held_pcp4", if_id_pcp4, 32'h0000_0004);
      check("held_pc", imem_addr, 32'h0000_0004);
      @(posedge clk); #1;
      scramble_dont_cares();
    end
    hazard_hold = 1'b0;
    pcsel = 2'd0;
    if_id_stall = 1'b0;
    #1;
    check("unhold_adv", {31'b0, if_advance}, 32'd1);
    sb.push_back('{32'hDEAD_BEEF, 32'h0000_0008, 1'b1});
    @(posedge clk); #1;
    sb_compare();
    check("post_hold_req", {31'b0, imem_req}, 32'd1);
    check("post_hold_addr", imem_addr, 32'h0000_0008);

    // Reset while WAIT, then a stale response in the first cycle after release.
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("mid_rst_instr", if_id_instr, 32'h0);
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0000_0400);
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    pcsel = 2'd1;
    br_target = 32'h7777_0000;
    if_id_stall = 1'b0;
    #1;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0000_0400);
    check("rel_no_adv", {31'b0, if_advance}, 32'd0);
    @(posedge clk); #1;
    imem_valid = 1'b0;
    check("stale_valid", {31'b0, if_id_valid}, 32'd0);
    check("stale_instr", if_id_instr, 32'h0);
    check("stale_pc", imem_addr, 32'h0000_0400);
    imem_valid = 1'b1;
    imem_rdata = 32'h3333_0000;
    pcsel = 2'd0;
    if_id_stall = 1'b0;
    sb.push_back('{32'h3333_0000, 32'h0000_0404, 1'b1});
    @(posedge clk); #1;
    imem_valid = 1'b0;
    sb_compare();
    check("after_rst_addr", imem_addr, 32'h0000_0404);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
